// File: rtl/mips_cpu_mem_if.sv
// rtl/mips_cpu_mem_if.sv - Avalon-MM bus controller for the multicycle MIPS core fetch/memory states
// Optional alignment trap enabled by defining MEM_IF_ALIGN_CHECK_EN.
module mips_cpu_mem_if #(
    parameter logic [31:0] RESET_ADDR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [1:0]  core_size,
    input  logic        core_signed,
    input  logic [31:0] core_wdata,
    output logic        core_busy,
    output logic        core_done,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;

    logic        reqWe;
    logic [1:0]  reqLane;
    logic [1:0]  reqSize;
    logic        reqSigned;

    logic [3:0]  laneByteEn;
    logic [31:0] laneWdata;
    logic        misaligned;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadData;

    // Byte enables and replicated store data, derived straight from the incoming request
    always_comb begin
        laneByteEn = 4'b1111;
        laneWdata  = core_wdata;
        case (core_size)
            2'b00: begin
                laneByteEn = 4'b0001 << core_addr[1:0];
                laneWdata  = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                laneByteEn = core_addr[1] ? 4'b1100 : 4'b0011;
                laneWdata  = {2{core_wdata[15:0]}};
            end
            default: begin
                laneByteEn = 4'b1111;
                laneWdata  = core_wdata;
            end
        endcase
    end

`ifdef MEM_IF_ALIGN_CHECK_EN
    assign misaligned = ((core_size == 2'b01) && core_addr[0]) ||
                        (core_size[1] && (core_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane extraction and extension of the returning read beat
    always_comb begin
        loadByte = 8'h00;
        case (reqLane)
            2'd0:    loadByte = readdata[7:0];
            2'd1:    loadByte = readdata[15:8];
            2'd2:    loadByte = readdata[23:16];
            default: loadByte = readdata[31:24];
        endcase
        loadHalf = reqLane[1] ? readdata[31:16] : readdata[15:0];
        case (reqSize)
            2'b00:   loadData = {{24{reqSigned & loadByte[7]}}, loadByte};
            2'b01:   loadData = {{16{reqSigned & loadHalf[15]}}, loadHalf};
            default: loadData = readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (core_req && !misaligned) begin
                    nextState = BUS;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    nextState = reqWe ? IDLE : RDATA;
                end
            end
            RDATA: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign core_busy = (state != IDLE);

    // core_done/core_err are single-cycle pulses; everything else holds until rewritten
    always_ff @(posedge clk) begin
        if (!reset) begin
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
            address    <= RESET_ADDR;
            core_done  <= 1'b0;
            core_err   <= 1'b0;
            core_rdata <= 32'h0;
            reqWe      <= 1'b0;
            reqLane    <= 2'b00;
            reqSize    <= 2'b00;
            reqSigned  <= 1'b0;
        end else begin
            core_done <= 1'b0;
            core_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req) begin
                        if (misaligned) begin
                            core_done <= 1'b1;
                            core_err  <= 1'b1;
                        end else begin
                            reqWe      <= core_we;
                            reqLane    <= core_addr[1:0];
                            reqSize    <= core_size;
                            reqSigned  <= core_signed;
                            address    <= {core_addr[31:2], 2'b00};
                            byteenable <= laneByteEn;
                            writedata  <= laneWdata;
                            read       <= ~core_we;
                            write      <= core_we;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (reqWe) begin
                            core_done <= 1'b1;
                        end
                    end
                end
                RDATA: begin
                    core_rdata <= loadData;
                    core_done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_if.sv
// tb/tb_mips_cpu_mem_if.sv - self-checking bench for mips_cpu_mem_if
module tb_mips_cpu_mem_if;

    localparam logic [31:0] RST_ADDR = 32'hBFC00000;

    logic        clk;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [1:0]  core_size;
    logic        core_signed;
    logic [31:0] core_wdata;
    logic        core_busy;
    logic        core_done;
    logic [31:0] core_rdata;
    logic        core_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int          nChecks = 0;
    int          nFails = 0;
    logic [31:0] lastRdata = 32'h0;

    mips_cpu_mem_if #(.RESET_ADDR(RST_ADDR)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_size   (core_size),
        .core_signed (core_signed),
        .core_wdata  (core_wdata),
        .core_busy   (core_busy),
        .core_done   (core_done),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle", {core_busy, core_done, read, write}, 4'b0000);
        end
    endtask

    // Reference: byte lanes, replicated store data and extended load data from plain arithmetic
    task automatic model(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         output logic [3:0] be, output logic [31:0] wd,
                         output logic [31:0] ld, output bit mis);
        int unsigned lane;
        int unsigned half;
        logic [31:0] v;
        lane = addr % 4;
        half = (addr / 2) % 2;
        mis  = 1'b0;
        if (size == 2'd0) begin
            be = 4'(1 << lane);
            wd = (wdata % 256) * 32'h01010101;
            v  = (rdata >> (8 * lane)) % 256;
            ld = (sgn && v >= 128) ? v + 32'hFFFFFF00 : v;
        end else if (size == 2'd1) begin
            be = 4'(3 << (2 * half));
            wd = (wdata % 65536) * 32'h00010001;
            v  = (rdata >> (16 * half)) % 65536;
            ld = (sgn && v >= 32768) ? v + 32'hFFFF0000 : v;
`ifdef MEM_IF_ALIGN_CHECK_EN
            mis = (addr % 2) != 0;
`endif
        end else begin
            be = 4'hF;
            wd = wdata;
            ld = rdata;
`ifdef MEM_IF_ALIGN_CHECK_EN
            mis = lane != 0;
`endif
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the done cycle
    task automatic doTxn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input int waits,
                         input logic [31:0] rdata);
        logic [3:0]  eBe;
        logic [31:0] eWd;
        logic [31:0] eLoad;
        bit          mis;
        model(addr, size, sgn, wdata, rdata, eBe, eWd, eLoad, mis);
        core_req    = 1'b1;
        core_we     = we;
        core_addr   = addr;
        core_size   = size;
        core_signed = sgn;
        core_wdata  = wdata;
        waitrequest = (waits > 0);
        readdata    = $urandom;
        @(negedge clk);
        core_req    = 1'b0;
        core_we     = 1'($urandom);
        core_addr   = $urandom;
        core_size   = 2'($urandom);
        core_signed = 1'($urandom);
        core_wdata  = $urandom;
        if (mis) begin
            chk("misalign", {core_busy, core_done, core_err, read, write, core_rdata},
                {5'b01100, lastRdata});
        end else begin
            for (int c = 1; c <= waits + 1; c++) begin
                waitrequest = (c <= waits);
                chk("bus", {core_busy, core_done, read, write, address, byteenable,
                            we ? writedata : 32'h0},
                    {2'b10, ~we, we, addr & 32'hFFFFFFFC, eBe, we ? eWd : 32'h0});
                @(negedge clk);
            end
            waitrequest = 1'($urandom);
            if (we) begin
                chk("store_done", {core_busy, core_done, core_err, read, write, core_rdata},
                    {5'b01000, lastRdata});
            end else begin
                readdata = rdata;
                chk("rdata_cyc", {core_busy, core_done, read, write}, 4'b1000);
                @(negedge clk);
                readdata  = $urandom;
                lastRdata = eLoad;
                chk("load_done", {core_busy, core_done, core_err, read, write, core_rdata},
                    {5'b01000, eLoad});
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        core_req    = 1'b0;
        core_we     = 1'b0;
        core_addr   = 32'h0;
        core_size   = 2'b00;
        core_signed = 1'b0;
        core_wdata  = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset", {core_busy, core_done, core_err, read, write, byteenable, writedata,
                      address, core_rdata},
            {5'b00000, 4'h0, 32'h0, RST_ADDR, 32'h0});
        reset = 1'b1;
        idle(2);

        doTxn(1'b0, 32'h00001004, 2'd2, 1'b0, 32'h0, 0, 32'hDEADBEEF);
        chk("word_load", core_rdata, 32'hDEADBEEF);
        idle(1);
        doTxn(1'b0, 32'h00000003, 2'd0, 1'b1, 32'h0, 0, 32'h80FF7F00);
        chk("lb_signed", core_rdata, 32'hFFFFFF80);
        idle(1);
        doTxn(1'b0, 32'h00000003, 2'd0, 1'b0, 32'h0, 0, 32'h80FF7F00);
        chk("lbu", core_rdata, 32'h00000080);
        idle(1);
        doTxn(1'b1, 32'h00000012, 2'd1, 1'b0, 32'h0000ABCD, 3, 32'h0);
        chk("half_store_rdata_hold", core_rdata, 32'h00000080);
        idle(1);

        // Reset while stalled abandons the request
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h00000040; core_size = 2'd2;
        waitrequest = 1'b1;
        @(negedge clk);
        core_req = 1'b0;
        chk("stall_read", {read, core_busy}, 2'b11);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset", {read, write, core_busy, core_done, address},
            {4'b0000, RST_ADDR});
        reset = 1'b1;
        waitrequest = 1'b0;
        lastRdata = 32'h0;
        idle(2);
        doTxn(1'b0, 32'h00000102, 2'd1, 1'b1, 32'h0, 1, 32'h9ABC1234);
        chk("after_reset_lh", core_rdata, 32'hFFFF9ABC);

        // Back-to-back: next request raised in the done cycle
        idle(1);
        doTxn(1'b1, 32'h00000021, 2'd0, 1'b0, 32'h000000A5, 0, 32'h0);
        doTxn(1'b1, 32'h00000024, 2'd2, 1'b0, 32'h12345678, 0, 32'h0);
        doTxn(1'b0, 32'h00000026, 2'd1, 1'b0, 32'h0, 2, 32'h8001C0DE);
        idle(2);

`ifdef MEM_IF_ALIGN_CHECK_EN
        doTxn(1'b0, 32'h00000002, 2'd2, 1'b0, 32'h0, 0, 32'h11111111);
        idle(1);
`endif

        for (int t = 0; t < 60; t++) begin
            doTxn(1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom,
                  int'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
